// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed driver for two 4-digit seven-segment blocks showing
//   hh-mm-ss-xx from packed-BCD stopwatch buses. A free-running slot divider
//   steps a shared digit select. Inputs are snapshotted once per frame so a
//   frame is always coherent. Each slot opens with a blank window to suppress
//   ghosting. Masked fields blink while in set mode.
//
// Ports
//   clk, rst      system clock; asynchronous active-low reset
//   en            display enable (0 darkens outputs, counters keep running)
//   hh/mm/ss/xx   packed BCD {tens,units}
//   blink_mask    {hh,mm,ss,xx}, 1 = blink that field
//   wei           one-hot digit select, shared by both blocks
//   duan/duan1    right/left block segments {dp,g,f,e,d,c,b,a}, active-high
module seg_scan_driver #(
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 1000,
  parameter int BLINK_HALF = 500,
  parameter int DP_EN      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic [7:0] xx,
  input  logic [3:0] blink_mask,
  output logic [3:0] wei,
  output logic [7:0] duan,
  output logic [7:0] duan1
);

  localparam int   CW    = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int   BW    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic DP_ON = (DP_EN != 0);

  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d; // 1 = hidden
  logic [31:0]   snap_q, snap_d;                // {hh,mm,ss,xx}
  logic [3:0]    wei_q, wei_d;
  logic [7:0]    duan_q, duan_d, duan1_q, duan1_d;

  logic          slot_tick;
  logic [3:0]    r_nib, l_nib;
  logic          r_fld, l_fld, r_dp, l_dp;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h40; // non-BCD nibble shows '-'
    endcase
  endfunction

  always_comb begin
    slot_tick  = (scan_cnt_q == CW'(SCAN_DIV - 1));
    scan_cnt_d = slot_tick ? '0 : scan_cnt_q + CW'(1);
    idx_d      = slot_tick ? idx_q + 2'd1 : idx_q;

    // Capture on the last slot of a frame so idx 0 of the next frame
    // already sees the fresh sample.
    snap_d = snap_q;
    if (slot_tick && idx_q == 2'd3) snap_d = {hh, mm, ss, xx};

    // Held at visible whenever no field is masked, so every set-mode entry
    // starts with a full visible half-period.
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (blink_mask == 4'b0000) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (slot_tick) begin
      if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    // Right block: xx then ss; left block: mm then hh (units first).
    r_nib = snap_q[3:0];   l_nib = snap_q[19:16];
    r_fld = blink_mask[0]; l_fld = blink_mask[2];
    r_dp  = 1'b0;          l_dp  = 1'b1;
    case (idx_q)
      2'd1: begin
        r_nib = snap_q[7:4];   l_nib = snap_q[23:20];
        l_dp  = 1'b0;
      end
      2'd2: begin
        r_nib = snap_q[11:8];  l_nib = snap_q[27:24];
        r_fld = blink_mask[1]; l_fld = blink_mask[3];
        r_dp  = 1'b1;
      end
      2'd3: begin
        r_nib = snap_q[15:12]; l_nib = snap_q[31:28];
        r_fld = blink_mask[1]; l_fld = blink_mask[3];
        l_dp  = 1'b0;
      end
      default: ;
    endcase

    wei_d   = 4'b0001 << idx_q;
    duan_d  = {r_dp & DP_ON, (blink_phase_q & r_fld) ? 7'h00 : seg7(r_nib)};
    duan1_d = {l_dp & DP_ON, (blink_phase_q & l_fld) ? 7'h00 : seg7(l_nib)};
    if (!en || scan_cnt_q < CW'(BLANK_CYC)) begin
      wei_d   = '0;
      duan_d  = '0;
      duan1_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      snap_q        <= '0;
      wei_q         <= '0;
      duan_q        <= '0;
      duan1_q       <= '0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      snap_q        <= snap_d;
      wei_q         <= wei_d;
      duan_q        <= duan_d;
      duan1_q       <= duan1_d;
    end
  end

  assign wei   = wei_q;
  assign duan  = duan_q;
  assign duan1 = duan1_q;

endmodule
